// File: rtl/imm_pkg.sv
// Shared types and constants for the decode-stage immediate extender.
package imm_pkg;

   localparam int ROT_W  = 4;
   localparam int IMM8_W = 8;
   localparam int SRC_W  = 3;

   typedef enum logic [SRC_W-1:0] {
      IMM8   = 3'b000,
      IMM12  = 3'b001,
      BRANCH = 3'b010,
      ROT    = 3'b011,
      SIMM12 = 3'b100,
      HALF   = 3'b101
   } imm_src_e;

   // Rotate a 32-bit word right by twice the 4-bit rotate field.
   // Shifting the doubled word keeps the wrapped bits without a second shifter.
   function automatic logic [31:0] ror32(input logic [31:0] v, input logic [ROT_W-1:0] rot);
      return 32'(({v, v}) >> {rot, 1'b0});
   endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Handshake and data bundle between decode, the extender and the execute operand mux.
interface imm_extend_pipe_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [23:0]       Instr;
   logic [2:0]        ImmSrc;
   logic              c_in;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] ExtImm;
   logic              shift_carry;
   logic              illegal;

   // Decode side: presents fields, flushes, and consumes the result.
   modport master (
      output in_valid, Instr, ImmSrc, c_in, flush, out_ready,
      input  in_ready, out_valid, ExtImm, shift_carry, illegal
   );

   // Extender side.
   modport slave (
      input  in_valid, Instr, ImmSrc, c_in, flush, out_ready,
      output in_ready, out_valid, ExtImm, shift_carry, illegal
   );
endinterface

// File: rtl/imm_pipe_reg.sv
// One valid/ready register slice with synchronous flush. No skid buffer:
// in_ready is combinational on out_ready.
module imm_pipe_reg #(
   parameter type res_t = logic
) (
   input  logic clk,
   input  logic rst_b,
   input  logic flush,
   input  logic in_valid,
   output logic in_ready,
   input  res_t in_data,
   output logic out_valid,
   input  logic out_ready,
   output res_t out_data
);

   logic load;

   assign load     = !out_valid || out_ready;
   assign in_ready = load;

   // Valid follows the upstream on load, flush empties the slot; data only
   // moves on a real capture so a stalled result stays stable.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (load) begin
            out_valid <= in_valid;
         end
         if (load && in_valid && !flush) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender for the decode stage. The extension is
// resolved combinationally in front of the first slice; the slices only
// carry {ext, carry, illegal}.
module imm_extend_pipe
   import imm_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic clk,
   input  logic reset_n,
   imm_extend_pipe_if.slave bus
);

   typedef struct packed {
      logic [DATA_W-1:0] ext;
      logic              carry;
      logic              illegal;
   } imm_res_t;

   logic [1:0]         rst_pipe;
   logic               rst_sync_b;
   logic [ROT_W-1:0]   rot;
   logic [IMM8_W-1:0]  imm8;
   logic [31:0]        rot32;
   logic signed [25:0] br_off;
   logic signed [11:0] s12;
   imm_res_t           res_c;

   // Reset asserts asynchronously and releases two clocks later, so no slice
   // leaves reset on a different edge than its neighbour.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_pipe <= 2'b00;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b1};
      end
   end

   assign rst_sync_b = rst_pipe[1];

   // Mode decode and extension; reserved modes give zero with illegal set.
   always_comb begin
      rot         = bus.Instr[11:8];
      imm8        = bus.Instr[7:0];
      rot32       = ror32({24'd0, imm8}, rot);
      br_off      = {bus.Instr, 2'b00};
      s12         = bus.Instr[11:0];
      res_c       = '0;
      res_c.carry = bus.c_in;
      case (bus.ImmSrc)
         IMM8:    res_c.ext = DATA_W'(imm8);
         IMM12:   res_c.ext = DATA_W'(bus.Instr[11:0]);
         BRANCH:  res_c.ext = DATA_W'(br_off);
         ROT: begin
            res_c.ext = DATA_W'(rot32);
            if (rot != '0) begin
               res_c.carry = rot32[31];
            end
         end
         SIMM12:  res_c.ext = DATA_W'(s12);
         HALF:    res_c.ext = DATA_W'({bus.Instr[11:8], bus.Instr[3:0]});
         default: res_c.illegal = 1'b1;
      endcase
   end

   for (genvar i = 0; i < LATENCY; i++) begin : g_stage
      imm_res_t d_in;
      imm_res_t d_out;
      logic     v_in;
      logic     v_out;
      logic     r_in;
      logic     r_out;

      if (i == 0) begin : g_first
         assign v_in = bus.in_valid;
         assign d_in = res_c;
      end else begin : g_mid
         assign v_in = g_stage[i-1].v_out;
         assign d_in = g_stage[i-1].d_out;
      end

      if (i == LATENCY - 1) begin : g_last
         assign r_out = bus.out_ready;
      end else begin : g_nlast
         assign r_out = g_stage[i+1].r_in;
      end

      imm_pipe_reg #(
         .res_t(imm_res_t)
      ) u_reg (
         .clk      (clk),
         .rst_b    (rst_sync_b),
         .flush    (bus.flush),
         .in_valid (v_in),
         .in_ready (r_in),
         .in_data  (d_in),
         .out_valid(v_out),
         .out_ready(r_out),
         .out_data (d_out)
      );
   end

   // Nothing is offered upstream until the synchronised reset has released.
   assign bus.in_ready    = g_stage[0].r_in & rst_sync_b;
   assign bus.out_valid   = g_stage[LATENCY-1].v_out;
   assign bus.ExtImm      = g_stage[LATENCY-1].d_out.ext;
   assign bus.shift_carry = g_stage[LATENCY-1].d_out.carry;
   assign bus.illegal     = g_stage[LATENCY-1].d_out.illegal;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: instance A (parameterisable, default 32/2) gets
// directed tables and sequences, instance B (64/1) shares the stimulus; both
// are tracked by a queue-based reference model.
module tb_imm_extend_pipe;

   localparam int DW_A  = 32;
   localparam int LAT_A = 2;
   localparam int DW_B  = 64;
   localparam int LAT_B = 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        c_in = 1'b0;
   logic        out_ready = 1'b1;
   logic        out_ready_b = 1'b1;
   logic [23:0] instr = '0;
   logic [2:0]  src = '0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   imm_extend_pipe_if #(.DATA_W(DW_A)) bus_a ();
   imm_extend_pipe_if #(.DATA_W(DW_B)) bus_b ();

   assign bus_a.in_valid  = in_valid;
   assign bus_a.Instr     = instr;
   assign bus_a.ImmSrc    = src;
   assign bus_a.c_in      = c_in;
   assign bus_a.flush     = flush;
   assign bus_a.out_ready = out_ready;
   assign bus_b.in_valid  = in_valid;
   assign bus_b.Instr     = instr;
   assign bus_b.ImmSrc    = src;
   assign bus_b.c_in      = c_in;
   assign bus_b.flush     = flush;
   assign bus_b.out_ready = out_ready_b;

   imm_extend_pipe #(.DATA_W(DW_A), .LATENCY(LAT_A)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a.slave));
   imm_extend_pipe #(.DATA_W(DW_B), .LATENCY(LAT_B)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b.slave));

   typedef struct {
      logic [63:0] ext;
      logic        carry;
      logic        ill;
   } res_t;

   typedef struct {
      logic [2:0]  src;
      logic [23:0] ins;
      logic        cin;
      logic [63:0] ext;
      logic        carry;
      logic        ill;
      string       name;
   } vec_t;

   // Reference: value of the immediate as a number, built by plain arithmetic.
   function automatic res_t model(input logic [2:0] s, input logic [23:0] ins, input logic cin);
      res_t        r;
      longint      v;
      logic [63:0] x;
      int          amt;
      r.ext   = '0;
      r.carry = cin;
      r.ill   = 1'b0;
      case (s)
         3'd0: r.ext = 64'(ins[7:0]);
         3'd1: r.ext = 64'(ins[11:0]);
         3'd2: begin
            v = longint'({40'd0, ins});
            if (ins[23]) v = v - 64'sd16777216;
            r.ext = 64'(v * 4);
         end
         3'd3: begin
            x   = 64'(ins[7:0]);
            amt = 2 * int'(ins[11:8]);
            for (int k = 0; k < amt; k++) x = (x >> 1) | ((x & 64'd1) << 31);
            r.ext = x;
            if (amt != 0) r.carry = x[31];
         end
         3'd4: begin
            v = longint'({52'd0, ins[11:0]});
            if (ins[11]) v = v - 64'sd4096;
            r.ext = 64'(v);
         end
         3'd5: r.ext = 64'(ins[11:8]) * 64'd16 + 64'(ins[3:0]);
         default: r.ill = 1'b1;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] trunc(input logic [63:0] v, input int dw);
      return (dw >= 64) ? v : (v & ((64'd1 << dw) - 64'd1));
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboards: the in-flight set is a FIFO; flush empties it, reset empties it.
   res_t qa[$];
   res_t qb[$];

   always @(negedge reset_n) begin
      qa.delete();
      qb.delete();
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (bus_a.out_valid) begin
            if (qa.size() == 0) chk("a_out_without_entry", bus_a.out_valid, 0);
            else begin
               chk("a_ext", bus_a.ExtImm, trunc(qa[0].ext, DW_A));
               chk("a_carry", bus_a.shift_carry, qa[0].carry);
               chk("a_illegal", bus_a.illegal, qa[0].ill);
               if (out_ready) void'(qa.pop_front());
            end
         end
         if (flush) qa.delete();
         else if (in_valid && bus_a.in_ready) begin
            qa.push_back(model(src, instr, c_in));
            if (qa.size() > LAT_A) chk("a_capacity_in_ready", bus_a.in_ready, 0);
         end

         if (bus_b.out_valid) begin
            if (qb.size() == 0) chk("b_out_without_entry", bus_b.out_valid, 0);
            else begin
               chk("b_ext", bus_b.ExtImm, trunc(qb[0].ext, DW_B));
               chk("b_carry", bus_b.shift_carry, qb[0].carry);
               chk("b_illegal", bus_b.illegal, qb[0].ill);
               if (out_ready_b) void'(qb.pop_front());
            end
         end
         if (flush) qb.delete();
         else if (in_valid && bus_b.in_ready) begin
            qb.push_back(model(src, instr, c_in));
            if (qb.size() > LAT_B) chk("b_capacity_in_ready", bus_b.in_ready, 0);
         end
      end
   end

   // Offer one input on A, check its latency and value, then let it drain.
   task automatic send_one(input string name, input logic [2:0] s, input logic [23:0] ins,
                           input logic cin, input logic [63:0] e_ext, input logic e_c,
                           input logic e_i);
      int t;
      int lat;
      t = 0;
      while (!bus_a.in_ready && t < 20) begin
         tick();
         t++;
      end
      chk({name, "_ready_wait"}, bus_a.in_ready, 1);
      src = s; instr = ins; c_in = cin; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!bus_a.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({name, "_latency"}, lat, LAT_A - 1);
      chk({name, "_ext"}, bus_a.ExtImm, trunc(e_ext, DW_A));
      chk({name, "_carry"}, bus_a.shift_carry, e_c);
      chk({name, "_illegal"}, bus_a.illegal, e_i);
      tick();
   endtask

   vec_t tbl[12];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ni;
      int no;
      bit started;
      bit rdy_done;

      tbl[0]  = '{3'd3, 24'h0004FF, 1'b0, 64'h00000000FF000000, 1'b1, 1'b0, "rot_4ff"};
      tbl[1]  = '{3'd3, 24'h000080, 1'b1, 64'h0000000000000080, 1'b1, 1'b0, "rot_zero"};
      tbl[2]  = '{3'd3, 24'h000F01, 1'b1, 64'h0000000000000004, 1'b0, 1'b0, "rot_30"};
      tbl[3]  = '{3'd3, 24'h000102, 1'b0, 64'h0000000080000000, 1'b1, 1'b0, "rot_2"};
      tbl[4]  = '{3'd2, 24'hFFFFFE, 1'b0, 64'hFFFFFFFFFFFFFFF8, 1'b0, 1'b0, "br_neg"};
      tbl[5]  = '{3'd2, 24'h000001, 1'b1, 64'h0000000000000004, 1'b1, 1'b0, "br_pos"};
      tbl[6]  = '{3'd4, 24'h000800, 1'b0, 64'hFFFFFFFFFFFFF800, 1'b0, 1'b0, "simm_neg"};
      tbl[7]  = '{3'd4, 24'h0007FF, 1'b1, 64'h00000000000007FF, 1'b1, 1'b0, "simm_pos"};
      tbl[8]  = '{3'd5, 24'h000A05, 1'b0, 64'h00000000000000A5, 1'b0, 1'b0, "half"};
      tbl[9]  = '{3'd7, 24'h123456, 1'b1, 64'h0000000000000000, 1'b1, 1'b1, "reserved"};
      tbl[10] = '{3'd0, 24'hABC03C, 1'b0, 64'h000000000000003C, 1'b0, 1'b0, "imm8_after"};
      tbl[11] = '{3'd1, 24'hFFFABC, 1'b0, 64'h0000000000000ABC, 1'b0, 1'b0, "imm12"};

      // Reset state while reset is held.
      #1;
      chk("rst_a_out_valid", bus_a.out_valid, 0);
      chk("rst_a_ext", bus_a.ExtImm, 0);
      chk("rst_a_carry", bus_a.shift_carry, 0);
      chk("rst_a_illegal", bus_a.illegal, 0);
      chk("rst_a_in_ready", bus_a.in_ready, 0);
      chk("rst_b_out_valid", bus_b.out_valid, 0);
      chk("rst_b_ext", bus_b.ExtImm, 0);
      #21 reset_n = 1'b1;
      tick();

      // Mode table.
      for (int i = 0; i < 12; i++)
         send_one(tbl[i].name, tbl[i].src, tbl[i].ins, tbl[i].cin,
                  tbl[i].ext, tbl[i].carry, tbl[i].ill);

      // Backpressure: four back-to-back inputs, output stalled for 6 cycles.
      ni = 0; no = 0; started = 0; rdy_done = 0;
      for (int t = 0; t < 40 && no < 4; t++) begin
         out_ready = (t >= 6);
         in_valid  = (ni < 4);
         src = 3'd1; instr = 24'h000101 + 24'(ni); c_in = 1'b0;
         #1;
         if (t < 6 && ni == LAT_A && !rdy_done) begin
            chk("bp_in_ready_full", bus_a.in_ready, 0);
            rdy_done = 1;
         end
         if (t < 6 && bus_a.out_valid) chk("bp_hold", bus_a.ExtImm, 64'h101);
         if (started && no < 4) chk("bp_no_gap", bus_a.out_valid, 1);
         if (bus_a.out_valid && out_ready) begin
            chk("bp_order", bus_a.ExtImm, 64'h101 + 64'(no));
            no++;
            started = 1;
         end
         if (in_valid && bus_a.in_ready) ni++;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_count", no, 4);
      repeat (2) tick();

      // Flush with an input offered in the same cycle while the pipe is full.
      out_ready = 1'b0;
      for (int k = 0; k < LAT_A; k++) begin
         src = 3'd1; instr = 24'h000200 + 24'(k); in_valid = 1'b1;
         tick();
      end
      instr = 24'h0007EE; flush = 1'b1; out_ready = 1'b1;
      #1;
      chk("flush_in_ready", bus_a.in_ready, 1);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", bus_a.out_valid, 0);
      for (int k = 0; k < LAT_A + 1; k++) begin
         tick();
         chk("flush_no_emit", bus_a.out_valid, 0);
      end
      send_one("post_flush", 3'd1, 24'h000155, 1'b0, 64'h155, 1'b0, 1'b0);

      // Reset pulse mid-stream, not aligned to the clock.
      out_ready = 1'b0;
      src = 3'd1; instr = 24'h000333; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", bus_a.out_valid, 0);
      chk("mid_rst_ext", bus_a.ExtImm, 0);
      chk("mid_rst_carry", bus_a.shift_carry, 0);
      chk("mid_rst_illegal", bus_a.illegal, 0);
      chk("mid_rst_b_ext", bus_b.ExtImm, 0);
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      tick();
      out_ready = 1'b1;
      chk("post_rst_out_valid", bus_a.out_valid, 0);
      send_one("post_rst", 3'd0, 24'h00005A, 1'b1, 64'h5A, 1'b1, 1'b0);

      // Random traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         in_valid    = ($urandom_range(0, 9) < 7);
         src         = 3'($urandom_range(0, 7));
         instr       = 24'($urandom());
         c_in        = 1'($urandom());
         out_ready   = ($urandom_range(0, 3) != 0);
         out_ready_b = ($urandom_range(0, 3) != 0);
         flush       = ($urandom_range(0, 39) == 0);
         tick();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; out_ready_b = 1'b1;
      repeat (6) tick();
      chk("a_drain_left", qa.size(), 0);
      chk("b_drain_left", qb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
